// File: rtl/sar_search_pkg.sv
// sar_search_pkg
//   Shared declarations for the successive-approximation search block:
//   the controller state enum, the default operand width and the helper
//   that sizes the step counter.
package sar_search_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TEST  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned W_DEF = 4;

   // A search uses at most W TEST compares plus one CHECK compare,
   // so the counter has to hold values 0..W+1.
   function automatic int unsigned steps_w(input int unsigned w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/sar_search_cmp.sv
// sar_search_cmp
//   Purely combinational magnitude comparator used as the partner of
//   sar_search. x is the trial operand, y the unknown value.
//   Ports:
//     x_i, y_i   : W-bit operands
//     greater_o  : x > y
//     equal_o    : x == y
//     smaller_o  : x < y
module sar_search_cmp #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic         greater_o,
   output logic         equal_o,
   output logic         smaller_o
);

   assign greater_o = (x_i > y_i);
   assign equal_o   = (x_i == y_i);
   assign smaller_o = (x_i < y_i);

endmodule

// File: rtl/sar_search.sv
// sar_search
//   Successive-approximation controller. Drives the trial operand of an
//   external combinational comparator and narrows down the unknown value
//   one bit per cycle, MSB first, with early exit on an equal flag and a
//   final CHECK compare once all bits are decided.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     start_i        : request a search (only looked at in IDLE)
//     trial_o        : operand presented to the comparator
//     greater_i/equal_i/smaller_i : comparator flags for trial_o
//     busy_o         : search in progress (TEST or CHECK)
//     done_o         : one-cycle completion pulse
//     result_o/found_o/error_o/steps_o : outcome, held until next start
module sar_search
   import sar_search_pkg::*;
#(
   parameter  int unsigned W  = W_DEF,
   localparam int unsigned SW = steps_w(W)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic [W-1:0]  trial_o,
   input  logic          greater_i,
   input  logic          equal_i,
   input  logic          smaller_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [W-1:0]  result_o,
   output logic          found_o,
   output logic          error_o,
   output logic [SW-1:0] steps_o
);

   localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;

   state_e          state_q, state_d;
   logic [W-1:0]    acc_q,   acc_d;
   logic [KW-1:0]   k_q,     k_d;
   logic [SW-1:0]   cnt_q,   cnt_d;
   logic [W-1:0]    res_q,   res_d;
   logic            fnd_q,   fnd_d;
   logic            err_q,   err_d;
   logic [SW-1:0]   stp_q,   stp_d;
   logic [W-1:0]    probe;

   function automatic logic flags_onehot(input logic g, input logic e, input logic s);
      return ({g, e, s} == 3'b100) || ({g, e, s} == 3'b010) || ({g, e, s} == 3'b001);
   endfunction

   // Candidate value with the bit under test set.
   assign probe = acc_q | (W'(1) << k_q);

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         fnd_q   <= 1'b0;
         err_q   <= 1'b0;
         stp_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         fnd_q   <= fnd_d;
         err_q   <= err_d;
         stp_q   <= stp_d;
      end
   end

   // Next-state and datapath update. The reported outcome is written on
   // the transition into DONE so it is already valid during the pulse.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      fnd_d   = fnd_q;
      err_d   = err_q;
      stp_d   = stp_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = TEST;
               acc_d   = '0;
               k_d     = KW'(W - 1);
               cnt_d   = '0;
               res_d   = '0;
               fnd_d   = 1'b0;
               err_d   = 1'b0;
               stp_d   = '0;
            end
         end
         TEST: begin
            cnt_d = cnt_q + SW'(1);
            if (!flags_onehot(greater_i, equal_i, smaller_i)) begin
               state_d = DONE;
               err_d   = 1'b1;
               res_d   = acc_q;
               stp_d   = cnt_d;
            end else if (equal_i) begin
               state_d = DONE;
               acc_d   = probe;
               fnd_d   = 1'b1;
               res_d   = probe;
               stp_d   = cnt_d;
            end else begin
               if (smaller_i) acc_d = probe;
               if (k_q == '0) state_d = CHECK;
               else           k_d     = k_q - KW'(1);
            end
         end
         CHECK: begin
            cnt_d   = cnt_q + SW'(1);
            state_d = DONE;
            res_d   = acc_q;
            stp_d   = cnt_d;
            if (!flags_onehot(greater_i, equal_i, smaller_i)) err_d = 1'b1;
            else if (equal_i)                                 fnd_d = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      trial_o = '0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         TEST:    begin trial_o = probe; busy_o = 1'b1; end
         CHECK:   begin trial_o = acc_q; busy_o = 1'b1; end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   assign result_o = res_q;
   assign found_o  = fnd_q;
   assign error_o  = err_q;
   assign steps_o  = stp_q;

endmodule
